// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : FSM state encoding and stall-length constants used by
//           hazard_detect and pipe_hazard_ctrl.
// Contents: state_t  - controller state (ST_RUN, ST_STALL)
//           REG_ZERO - register index that never carries a dependency
//           L_NONE, L_LOADUSE, L_JR_LOAD_EX - stall lengths in cycles

package hazard_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int       REG_ZERO     = 0;
  localparam bit [1:0] L_NONE       = 2'd0;
  localparam bit [1:0] L_LOADUSE    = 2'd1;
  localparam bit [1:0] L_JR_LOAD_EX = 2'd2;

  // Larger of two stall lengths; overlapping hazards resolve to the longest one.
  function automatic logic [1:0] max_len(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational stall-length detector for the ID stage
//
// Purpose : Computes how many cycles the ID instruction must wait for its
//           operands (0..2), from ID source use and EX/MEM destinations.
// Ports   : i_id_rs, i_id_rt         ID source register indices
//           i_id_use_rs, i_id_use_rt ID instruction reads rs / rt
//           i_id_jr                  JR in ID (target read in ID, no EX forwarding)
//           i_ex_reg_write           ID/EX instruction writes a register
//           i_ex_mem_read            ID/EX instruction is a load
//           i_ex_dst                 ID/EX destination register
//           i_mem_mem_read           EX/MEM instruction is a load
//           i_mem_dst                EX/MEM destination register
//           o_len                    required stall length in cycles

module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_jr,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_dst,
  input  logic             i_mem_mem_read,
  input  logic [REG_W-1:0] i_mem_dst,
  output logic [1:0]       o_len
);

  logic w_ex_dst_live;
  logic w_mem_dst_live;
  logic w_load_use;
  logic w_jr_ex;
  logic w_jr_mem;

  // Writes to register 0 are discarded, so they never create a dependency.
  assign w_ex_dst_live  = (i_ex_dst  != REG_W'(REG_ZERO));
  assign w_mem_dst_live = (i_mem_dst != REG_W'(REG_ZERO));

  // A load's data is only forwardable from MEM onward, so one bubble suffices.
  assign w_load_use = i_ex_mem_read && w_ex_dst_live &&
                      ((i_id_use_rs && (i_ex_dst == i_id_rs)) ||
                       (i_id_use_rt && (i_ex_dst == i_id_rt)));

  // JR consumes rs in ID itself, so any producer still in EX must drain first.
  assign w_jr_ex  = i_id_jr && i_ex_reg_write && w_ex_dst_live && (i_ex_dst == i_id_rs);
  assign w_jr_mem = i_id_jr && i_mem_mem_read && w_mem_dst_live && (i_mem_dst == i_id_rs);

  always_comb begin
    o_len = L_NONE;
    if (w_load_use) begin
      o_len = max_len(o_len, L_LOADUSE);
    end
    if (w_jr_ex) begin
      o_len = max_len(o_len, i_ex_mem_read ? L_JR_LOAD_EX : L_LOADUSE);
    end
    if (w_jr_mem) begin
      o_len = max_len(o_len, L_LOADUSE);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard and flow controller for the 5-stage MIPS pipeline
//
// Purpose : Drives PC / IF/ID / ID/EX controls for load-use and JR operand
//           stalls, J/JAL/JR squash, and taken-BEQ flush. Outputs are Mealy.
// Build   : define HAZARD_STATS_EN to add the stall_cycles / flush_count
//           statistics counters (and the CNT_W parameter).
// Ports   : CLK, Reset                 clock, synchronous active-high reset
//           id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr   ID fields
//           ex_reg_write, ex_mem_read, ex_dst                    ID/EX state
//           mem_mem_read, mem_dst                                EX/MEM state
//           ex_branch_taken            BEQ resolved taken in EX
//           pc_write, ifid_write       PC / IF/ID load enables
//           ifid_flush                 clear IF/ID to NOP
//           idex_bubble                zero ID/EX control fields
//           stall_cycles, flush_count  statistics (HAZARD_STATS_EN only)

module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
`endif
);

  state_t     r_state;
  logic [1:0] r_rem;
  logic [1:0] w_len;
  logic       w_squash;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_use_rs    (id_use_rs),
    .i_id_use_rt    (id_use_rt),
    .i_id_jr        (id_jr),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_dst       (ex_dst),
    .i_mem_mem_read (mem_mem_read),
    .i_mem_dst      (mem_dst),
    .o_len          (w_len)
  );

  // Squash only when the jump actually leaves ID this cycle (no branch, no stall).
  assign w_squash = !Reset && !ex_branch_taken && (r_state == ST_RUN) &&
                    (w_len == L_NONE) && (id_jump || id_jr);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Both the IF/ID and ID/EX instructions are on the wrong path.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((r_state == ST_STALL) || (w_len != L_NONE)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (w_squash) begin
      ifid_flush  = 1'b1;
    end
  end

  // Only a 2-cycle stall needs the STALL state; a 1-cycle stall is fully
  // covered by the RUN cycle itself and the hazard clears by the next cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_rem   <= 2'd0;
    end else if (ex_branch_taken) begin
      r_state <= ST_RUN;
      r_rem   <= 2'd0;
    end else if (r_state == ST_STALL) begin
      if (r_rem <= 2'd1) begin
        r_state <= ST_RUN;
        r_rem   <= 2'd0;
      end else begin
        r_rem   <= r_rem - 2'd1;
      end
    end else if (w_len > L_LOADUSE) begin
      r_state <= ST_STALL;
      r_rem   <= w_len - 2'd1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (ex_branch_taken || w_squash) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic             id_use_rs, id_use_rt, id_jump, id_jr;
  logic             ex_reg_write, ex_mem_read, mem_mem_read, ex_branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cycles, flush_count;
`endif

  pipe_hazard_ctrl #(.REG_W(REG_W)) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_jump         (id_jump),
    .id_jr           (id_jr),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_dst          (ex_dst),
    .mem_mem_read    (mem_mem_read),
    .mem_dst         (mem_dst),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble)
`ifdef HAZARD_STATS_EN
    , .stall_cycles  (stall_cycles)
    , .flush_count   (flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles of stall still owed, plus statistics totals.
  int          m_stall_left = 0;
  logic [31:0] m_stall_cnt  = 0;
  logic [31:0] m_flush_cnt  = 0;

  // Output encoding {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] O_RESET  = 4'b0011;
  localparam logic [3:0] O_FLUSH  = 4'b1111;
  localparam logic [3:0] O_STALL  = 4'b0001;
  localparam logic [3:0] O_SQUASH = 4'b1110;
  localparam logic [3:0] O_NORMAL = 4'b1100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int needed_stall();
    int l = 0;
    if (ex_mem_read && ex_dst != 0 &&
        ((id_use_rs && ex_dst == id_rs) || (id_use_rt && ex_dst == id_rt)))
      l = 1;
    if (id_jr && ex_reg_write && ex_dst != 0 && ex_dst == id_rs)
      l = (ex_mem_read ? 2 : ((l > 1) ? l : 1));
    if (id_jr && mem_mem_read && mem_dst != 0 && mem_dst == id_rs && l < 1)
      l = 1;
    return l;
  endfunction

  task automatic clear_inputs();
    Reset = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_jump = 0; id_jr = 0; ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
    mem_mem_read = 0; mem_dst = 0; ex_branch_taken = 0;
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic step(input string tag, input bit has_exp, input logic [3:0] exp_c);
    logic [3:0] exp_o;
    int l;
    @(negedge CLK);
    l = needed_stall();
    if (Reset)                  exp_o = O_RESET;
    else if (ex_branch_taken)   exp_o = O_FLUSH;
    else if (m_stall_left > 0)  exp_o = O_STALL;
    else if (l > 0)             exp_o = O_STALL;
    else if (id_jump || id_jr)  exp_o = O_SQUASH;
    else                        exp_o = O_NORMAL;
    check({tag, ".model"}, {pc_write, ifid_write, ifid_flush, idex_bubble}, exp_o);
    if (has_exp)
      check({tag, ".plan"}, {pc_write, ifid_write, ifid_flush, idex_bubble}, exp_c);
`ifdef HAZARD_STATS_EN
    check({tag, ".stall_cycles"}, stall_cycles, m_stall_cnt);
    check({tag, ".flush_count"}, flush_count, m_flush_cnt);
`endif
    @(posedge CLK);
    if (Reset) begin
      m_stall_left = 0;
      m_stall_cnt  = 0;
      m_flush_cnt  = 0;
    end else begin
      if (exp_o[3] == 1'b0) m_stall_cnt++;
      if (exp_o == O_FLUSH || exp_o == O_SQUASH) m_flush_cnt++;
      if (ex_branch_taken)        m_stall_left = 0;
      else if (m_stall_left > 0)  m_stall_left--;
      else if (l > 0)             m_stall_left = l - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    step("reset0", 1, O_RESET);
    step("reset1", 1, O_RESET);
    Reset = 0;
  endtask

  task automatic jr_hazard();
    id_jr = 1; id_rs = 31; id_use_rs = 1;
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 31;
  endtask

  initial begin
    do_reset();
`ifdef HAZARD_STATS_EN
    check("reset.stall_cycles", stall_cycles, 32'd0);
    check("reset.flush_count", flush_count, 32'd0);
`endif

    // Load-use: one stall cycle then normal flow.
    ex_mem_read = 1; ex_dst = 8; id_use_rs = 1; id_rs = 8;
    step("loaduse.stall", 1, O_STALL);
    clear_inputs();
    step("loaduse.after", 1, O_NORMAL);

    // JR on a load in EX: two stalls, then squash.
    jr_hazard();
    step("jr.stall0", 1, O_STALL);
    ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
    mem_mem_read = 1; mem_dst = 31;
    step("jr.stall1", 1, O_STALL);
    mem_mem_read = 0; mem_dst = 0;
    step("jr.squash", 1, O_SQUASH);
    clear_inputs();
    step("jr.after", 1, O_NORMAL);

    // Register 0 never creates a hazard.
    ex_mem_read = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
    step("r0.nostall", 1, O_NORMAL);
    clear_inputs();

    // Branch during the second JR stall cycle aborts the stall.
    jr_hazard();
    step("br.stall0", 1, O_STALL);
    clear_inputs();
    ex_branch_taken = 1;
    step("br.flush", 1, O_FLUSH);
    clear_inputs();
    step("br.run", 1, O_NORMAL);

    // Branch together with a new hazard: flush wins, no stall follows.
    jr_hazard();
    ex_branch_taken = 1;
    step("br.overhaz", 1, O_FLUSH);
    clear_inputs();
    step("br.overhaz.run", 1, O_NORMAL);

    // Reset held two edges in mid-STALL.
    jr_hazard();
    step("rst.stall0", 1, O_STALL);
    do_reset();
    clear_inputs();
    step("rst.after", 1, O_NORMAL);
`ifdef HAZARD_STATS_EN
    // One load-use stall plus one branch flush from a clean reset.
    do_reset();
    ex_mem_read = 1; ex_dst = 8; id_use_rt = 1; id_rt = 8;
    step("st.stall", 1, O_STALL);
    clear_inputs();
    ex_branch_taken = 1;
    step("st.flush", 1, O_FLUSH);
    clear_inputs();
    step("st.idle", 1, O_NORMAL);
    check("st.stall_cycles", stall_cycles, 32'd1);
    check("st.flush_count", flush_count, 32'd1);
`endif

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 800; i++) begin
      Reset           = ($urandom_range(0, 59) == 0);
      id_rs           = REG_W'($urandom_range(0, 3));
      id_rt           = REG_W'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom);
      id_use_rt       = 1'($urandom);
      id_jump         = ($urandom_range(0, 5) == 0);
      id_jr           = ($urandom_range(0, 3) == 0);
      ex_reg_write    = 1'($urandom);
      ex_mem_read     = 1'($urandom);
      ex_dst          = REG_W'($urandom_range(0, 3));
      mem_mem_read    = 1'($urandom);
      mem_dst         = REG_W'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      step("rand", 0, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
